// File: rtl/pia_bus_poller_if.sv
// pia_bus_poller_if: register bus to the PIA-style UART plus the rx/tx byte streams
interface pia_bus_poller_if;
  logic [1:0] bus_addr;
  logic       bus_wen;
  logic       bus_en;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  modport master (
    output bus_addr, bus_wen, bus_en, bus_wdata, rx_valid, rx_data, tx_ready,
    input  bus_rdata, rx_ready, tx_valid, tx_data
  );
  modport slave (
    input  bus_addr, bus_wen, bus_en, bus_wdata, rx_valid, rx_data, tx_ready,
    output bus_rdata, rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/pia_bus_poller.sv
// pia_bus_poller: polls a PIA-style UART (RX/RXCR/TX/TXCR) and exposes rx/tx valid-ready byte streams
// Optional PIA_POLL_CRLF_EN: every accepted 0x0D is followed by an automatic 0x0A write
module pia_bus_poller #(
  parameter int POLL_GAP  = 4,
  parameter int TX_SETTLE = 3
) (
  input logic clk,
  input logic rst,
  pia_bus_poller_if.master bus
);
  typedef enum logic [3:0] {
    INIT, INIT_SU, INIT_WR, GAP, PRE, RXCR_RD, RXCR_CHK, RX_PRE,
    RX_RD, RX_CAP, RX_HOLD, TXST_RD, TXST_CHK, TX_WR, SETTLE
  } state_t;
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP > 1 ? POLL_GAP - 1 : 0);
  localparam logic [7:0] SET_LAST = 8'(TX_SETTLE > 1 ? TX_SETTLE - 1 : 0);
  state_t     state, state_n;
  logic [7:0] cnt, rx_q, wr_byte;
  logic       last_tx, sel_tx, tx_want, wr_go;
`ifdef PIA_POLL_CRLF_EN
  logic lf_pend;
  always_ff @(posedge clk) begin
    if (rst) lf_pend <= 1'b0;
    else if (state == TX_WR) lf_pend <= wr_go && !lf_pend && bus.tx_data == 8'h0D;
  end
  assign tx_want     = bus.tx_valid | lf_pend;
  assign wr_byte     = lf_pend ? 8'h0A : bus.tx_data;
  assign bus.tx_ready = state == TX_WR && !lf_pend && bus.tx_valid;
`else
  assign tx_want     = bus.tx_valid;
  assign wr_byte     = bus.tx_data;
  assign bus.tx_ready = state == TX_WR && bus.tx_valid;
`endif
  // a TX_WR entered with nothing to send (tx_valid dropped) performs no access
  assign wr_go = state == TX_WR && tx_want;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      last_tx <= 1'b1;
      sel_tx  <= 1'b0;
      rx_q    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= state_n == state ? cnt + 8'd1 : '0;
      last_tx <= state == TXST_RD ? 1'b1 : state == RXCR_RD ? 1'b0 : last_tx;
      sel_tx  <= state == GAP ? !last_tx && tx_want : sel_tx;
      rx_q    <= state == RX_CAP ? {1'b0, bus.bus_rdata[6:0]} : rx_q;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      INIT:     state_n = INIT_SU;
      INIT_SU:  state_n = INIT_WR;
      INIT_WR:  state_n = SETTLE;
      GAP:      state_n = cnt >= GAP_LAST ? PRE : GAP;
      PRE:      state_n = sel_tx ? TXST_RD : RXCR_RD;
      RXCR_RD:  state_n = RXCR_CHK;
      RXCR_CHK: state_n = bus.bus_rdata[7] ? RX_PRE : GAP;
      RX_PRE:   state_n = RX_RD;
      RX_RD:    state_n = RX_CAP;
      RX_CAP:   state_n = RX_HOLD;
      RX_HOLD:  state_n = bus.rx_ready ? GAP : RX_HOLD;
      TXST_RD:  state_n = TXST_CHK;
      TXST_CHK: state_n = !bus.bus_rdata[7] && tx_want ? TX_WR : GAP;
      TX_WR:    state_n = wr_go ? SETTLE : GAP;
      SETTLE:   state_n = cnt >= SET_LAST ? GAP : SETTLE;
      default:  state_n = INIT;
    endcase
  end
  // every access state is preceded and followed by a cycle driving the same address
  assign bus.bus_en    = state inside {INIT_WR, RXCR_RD, RX_RD, TXST_RD} || wr_go;
  assign bus.bus_wen   = state == INIT_WR || wr_go;
  assign bus.bus_wdata = state == INIT_WR ? 8'h7F : wr_go ? wr_byte : 8'h00;
  assign bus.bus_addr  = state inside {INIT_SU, INIT_WR, TXST_RD, TXST_CHK, TX_WR, SETTLE} || (state == PRE && sel_tx) ? 2'b10 :
                         state inside {RXCR_RD, RXCR_CHK} || (state == PRE && !sel_tx) ? 2'b01 : 2'b00;
  assign bus.rx_valid  = state == RX_HOLD;
  assign bus.rx_data   = rx_q;
endmodule

// File: tb/tb_pia_bus_poller.sv
// tb_pia_bus_poller: PIA peripheral model, protocol monitor, vector table and randomized scoreboard
module tb_pia_bus_poller;
  localparam int TX_SETTLE = 3;
  localparam int BUSY = 10;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pia_bus_poller_if bus();
  pia_bus_poller #(.POLL_GAP(4), .TX_SETTLE(TX_SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // peripheral: one-byte rx buffer fed from inj_arr, tx line log, busy timer, ignore-first-write latch
  logic [7:0] p_rx = 8'h00, inj_arr [0:255];
  logic       p_full = 1'b0, p_first = 1'b1, force_busy = 1'b0;
  int         inj_wr = 0, inj_rd = 0, busy_cnt = 0, rx_reads = 0, txr_n = 0;
  logic [7:0] line_q [$];
  always @(posedge clk) begin
    if (bus.tx_ready) txr_n <= txr_n + 1;
    if (rst) begin
      p_full <= 1'b0;
      p_first <= 1'b1;
      busy_cnt <= 0;
      bus.bus_rdata <= 8'h00;
    end else begin
      bus.bus_rdata <= bus.bus_addr == 2'd0 ? p_rx : bus.bus_addr == 2'd1 ? {p_full, 7'd0} :
                       bus.bus_addr == 2'd2 ? {force_busy || busy_cnt != 0, 7'd0} : 8'h00;
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (bus.bus_en && !bus.bus_wen && bus.bus_addr == 2'd0) begin
        p_full <= 1'b0;
        rx_reads <= rx_reads + 1;
      end else if (!p_full && inj_rd != inj_wr) begin
        p_rx <= inj_arr[inj_rd[7:0]];
        inj_rd <= inj_rd + 1;
        p_full <= 1'b1;
      end
      if (bus.bus_en && bus.bus_wen && bus.bus_addr == 2'd2) begin
        if (p_first) p_first <= 1'b0;
        else begin
          line_q.push_back(bus.bus_wdata);
          busy_cnt <= BUSY;
        end
      end
    end
  end
  // bus protocol monitor
  int         cyc = 0, wr_n = 0, wr_cyc [0:255];
  logic [1:0] prev_addr = 2'd0, f_addr = 2'd0;
  logic       prev_en = 1'b0, prev_wen = 1'b0, first_seen = 1'b0, f_wen = 1'b0;
  logic [7:0] f_wdata = 8'h00, rxcr_last = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (rst) first_seen = 1'b0;
    else begin
      check("wen_only_with_en", bus.bus_wen & ~bus.bus_en, 0);
      if (bus.bus_en) begin
        check("addr_setup", bus.bus_addr, prev_addr);
        check("addr_not_3", bus.bus_addr == 2'd3, 0);
        if (!first_seen) begin
          first_seen = 1'b1;
          f_addr = bus.bus_addr;
          f_wen = bus.bus_wen;
          f_wdata = bus.bus_wdata;
        end
        if (bus.bus_wen && bus.bus_addr == 2'd2) begin
          wr_cyc[wr_n[7:0]] = cyc;
          wr_n++;
        end
      end
      if (prev_en) begin
        check("addr_hold", bus.bus_addr, prev_addr);
        check("en_one_cycle", bus.bus_en, 0);
        if (prev_addr == 2'd1 && !prev_wen) rxcr_last = bus.bus_rdata;
      end
    end
    prev_addr = bus.bus_addr;
    prev_en = bus.bus_en && !rst;
    prev_wen = bus.bus_wen;
  end
  task automatic inject(input logic [7:0] b);
    inj_arr[inj_wr[7:0]] = b;
    inj_wr++;
  endtask
  task automatic wait_rx(input string nm);
    int t = 0;
    while (!bus.rx_valid && t < 400) begin @(negedge clk); t++; end
    check({nm, "_rx_wait"}, bus.rx_valid, 1);
  endtask
  task automatic recv(output logic [7:0] b, input string nm);
    wait_rx(nm);
    b = bus.rx_data;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input string nm);
    int t = 0;
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    #1;
    while (!bus.tx_ready && t < 400) begin @(negedge clk); #1; t++; end
    check({nm, "_tx_accept"}, bus.tx_ready, 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic wait_line(input int n, input string nm);
    int t = 0;
    while (line_q.size() < n && t < 400) begin @(negedge clk); t++; end
    check({nm, "_line"}, line_q.size() >= n, 1);
  endtask
  task automatic check_reset(input string nm);
    check({nm, "_addr"}, bus.bus_addr, 0);
    check({nm, "_wen"}, bus.bus_wen, 0);
    check({nm, "_en"}, bus.bus_en, 0);
    check({nm, "_wdata"}, bus.bus_wdata, 0);
    check({nm, "_rx_valid"}, bus.rx_valid, 0);
    check({nm, "_rx_data"}, bus.rx_data, 0);
    check({nm, "_tx_ready"}, bus.tx_ready, 0);
  endtask
  typedef struct {
    logic       is_rx;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [6];
  initial begin
    logic [7:0] b, rb, tb_byte, exp_q [$];
    int r0, n0, w0, k0, mode, t;
    logic seen, stable;
    vecs = '{'{1'b1, 8'hC1, 8'h41}, '{1'b0, 8'h48, 8'h48}, '{1'b1, 8'h8D, 8'h0D},
             '{1'b0, 8'h7E, 8'h7E}, '{1'b1, 8'hFF, 8'h7F}, '{1'b0, 8'h00, 8'h00}};
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("first_seen", first_seen, 1);
    check("first_addr", f_addr, 2);
    check("first_wen", f_wen, 1);
    check("first_wdata", f_wdata, 8'h7F);
    check("init_line_empty", line_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_rx) begin
        r0 = rx_reads;
        inject(vecs[i].din);
        recv(b, "vec");
        check("vec_rx_data", b, vecs[i].exp);
        repeat (40) @(negedge clk);
        check("vec_single_ack", rx_reads - r0, 1);
        check("vec_rxcr_clear", rxcr_last, 0);
      end else begin
        n0 = line_q.size();
        send(vecs[i].din, "vec");
        wait_line(n0 + 1, "vec");
        check("vec_tx_line", line_q[n0], vecs[i].exp);
      end
    end
    // rx held while the consumer stalls; the second byte waits in the peripheral
    r0 = rx_reads;
    inject(8'hA5);
    inject(8'h3C);
    wait_rx("hold");
    b = bus.rx_data;
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.rx_data !== b || !bus.rx_valid) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_no_extra_read", rx_reads - r0, 1);
    recv(b, "hold1");
    check("hold_first", b, 8'h25);
    recv(b, "hold2");
    check("hold_second", b, 8'h3C);
    // back-to-back tx
    n0 = line_q.size();
    w0 = wr_n;
    send(8'h48, "b2b");
    send(8'h49, "b2b");
    wait_line(n0 + 2, "b2b");
    check("b2b_first", line_q[n0], 8'h48);
    check("b2b_second", line_q[n0 + 1], 8'h49);
    check("b2b_spacing", wr_cyc[w0 + 1] - wr_cyc[w0] >= TX_SETTLE + 2, 1);
    // busy status defers the write
    n0 = line_q.size();
    force_busy = 1'b1;
    bus.tx_data = 8'h55;
    bus.tx_valid = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      #1;
      if (bus.tx_ready) seen = 1'b1;
    end
    check("busy_no_accept", seen, 0);
    check("busy_no_write", line_q.size(), n0);
    force_busy = 1'b0;
    send(8'h55, "busy");
    wait_line(n0 + 1, "busy");
    check("busy_line", line_q[n0], 8'h55);
    // simultaneous rx and tx
    n0 = line_q.size();
    inject(8'hD2);
    fork
      send(8'h33, "sim");
      begin recv(b, "sim"); check("sim_rx", b, 8'h52); end
    join
    wait_line(n0 + 1, "sim");
    check("sim_tx", line_q[n0], 8'h33);
    // randomized traffic against a byte-level model
    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 2);
      rb = 8'($urandom);
      tb_byte = 8'($urandom);
      n0 = line_q.size();
      exp_q.delete();
      if (mode != 0) begin
        exp_q.push_back(tb_byte);
`ifdef PIA_POLL_CRLF_EN
        if (tb_byte == 8'd13) exp_q.push_back(8'd10);
`endif
      end
      if (mode != 1) inject(rb);
      fork
        if (mode != 0) send(tb_byte, "rnd");
        if (mode != 1) begin recv(b, "rnd"); check("rnd_rx", b, rb % 128); end
      join
      wait_line(n0 + exp_q.size(), "rnd");
      foreach (exp_q[j]) check("rnd_tx", line_q[n0 + j], exp_q[j]);
      repeat (20) @(negedge clk);
      check("rnd_no_extra_tx", line_q.size(), n0 + exp_q.size());
    end
`ifdef PIA_POLL_CRLF_EN
    n0 = line_q.size();
    k0 = txr_n;
    send(8'h0D, "crlf");
    wait_line(n0 + 2, "crlf");
    repeat (30) @(negedge clk);
    check("crlf_cr", line_q[n0], 8'h0D);
    check("crlf_lf", line_q[n0 + 1], 8'h0A);
    check("crlf_one_ready", txr_n - k0, 1);
    check("crlf_count", line_q.size(), n0 + 2);
`endif
    // reset right after a CR write, while the poller settles
    n0 = line_q.size();
    bus.tx_data = 8'h0D;
    bus.tx_valid = 1'b1;
    t = 0;
    while (line_q.size() <= n0 && t < 400) begin @(negedge clk); t++; end
    check("rst_cr_written", line_q.size(), n0 + 1);
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_reinit_seen", first_seen, 1);
    check("midrst_reinit_addr", f_addr, 2);
    check("midrst_reinit_wdata", f_wdata, 8'h7F);
    check("midrst_no_lf", line_q.size(), n0 + 1);
    check("midrst_cr", line_q[n0], 8'h0D);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pia_bus_poller.md
Name: pia_bus_poller

Overview:
- Bus initiator that drives the 4-register PIA-style UART peripheral (RX 0xD010, RXCR 0xD011, TX 0xD012, TXCR 0xD013) exactly as Wozmon does.
- Converts the register protocol into two valid/ready byte streams: received bytes out, transmit bytes in.
- Sits between the UART peripheral and hardware-side consumers, such as the loopback/echo path and the bring-up loader, where no 6502 is present.

Parameters:
- POLL_GAP, 4: idle cycles between consecutive poll transactions (range 0-255).
- TX_SETTLE, 3: cycles after a TX write before TX status may be sampled again; covers the peripheral's strobe-to-busy latency.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous to clk, active high
- bus_addr  out  2  register address to peripheral
- bus_wen  out  1  write strobe to peripheral
- bus_en  out  1  access strobe, mapped to the peripheral enable input
- bus_wdata  out  8  write data to peripheral din
- bus_rdata  in  8  peripheral dout; registered, valid one cycle after bus_addr
- rx_valid  out  1  received byte available
- rx_data  out  8  received byte, bit7 cleared
- rx_ready  in  1  consumer accepts rx_data
- tx_valid  in  1  byte offered for transmission
- tx_data  in  8  byte to transmit
- tx_ready  out  1  tx_data accepted this cycle

Behaviour:
- Reset values: bus_addr=2'b00, bus_wen=0, bus_en=0, bus_wdata=0, rx_valid=0, rx_data=0, tx_ready=0. FSM goes to INIT_WR. An in-flight access or held byte is discarded.
- bus_en is high for exactly one cycle per access. bus_addr stays stable from the cycle before bus_en through the cycle after it. bus_wen is high only together with bus_en.
- INIT_WR: one write of 0x7F to address 2'b10. This consumes the peripheral's ignore-first-write latch. Then go to GAP.
- GAP: count POLL_GAP cycles, then go to the next poll. Selection is round-robin starting with RX: RXCR_RD if last was TX or tx_valid=0, otherwise TXST_RD. With POLL_GAP=0, go directly.
- RXCR_RD: addr=01, read (bus_en=1, bus_wen=0). RXCR_CHK (next cycle): sample bus_rdata[7]. If 1, go to RX_RD; else go to GAP.
- RX_RD: addr=00, bus_en=1. This single access is the peripheral's acknowledge. RX_CAP (next cycle): rx_data <= {1'b0, bus_rdata[6:0]}, rx_valid <= 1. Then go to RX_HOLD.
- RX_HOLD: no bus activity, rx_data held stable. When rx_valid & rx_ready, clear rx_valid next cycle and go to GAP. TX polling is stalled while held.
- TXST_RD: addr=10, read. TXST_CHK: if bus_rdata[7]=1 (busy), go to GAP; else go to TX_WR.
- TX_WR: addr=10, bus_wen=1, bus_en=1, bus_wdata=tx_data. tx_ready=1 for this cycle only. Then go to SETTLE.
- SETTLE: wait TX_SETTLE cycles, then go to GAP.
- tx_valid dropping between TXST_CHK and TX_WR: abort to GAP with no write and tx_ready stays 0.
- Address 2'b11 is never accessed.
- rx_ready high while rx_valid=0 is ignored.

Optional Feature:
- PIA_POLL_CRLF_EN defined:
  - an accepted tx byte 0x0D is followed automatically by a second TX sequence writing 0x0A before tx_ready can assert again;
  - the 0x0A write follows the same status poll and SETTLE rules;
  - rst during the pending LF drops it.
- Undefined: bytes are written verbatim and no extra state exists.

Test Plan:
- After rst release, with the peripheral model attached: first access is a write of 0x7F to addr 2 with bus_en high for 1 cycle, and no byte reaches the serial TX line.
- Peripheral receives 0xC1: within 2 polls rx_valid=1, rx_data=0x41. RXCR then reads 0x00, and exactly one RX access occurs (single ack).
- rx_ready held 0 for 50 cycles while a second byte arrives: rx_data is stable at the first byte and no RX-register read occurs. After rx_ready, the second byte is delivered.
- tx_valid=1 with tx_data=0x48 then 0x49 back-to-back: two TX_WR writes separated by at least TX_SETTLE+status poll. A busy status (bit7=1) defers the write, and the line outputs 0x48, 0x49.
- Simultaneous RX pending and tx_valid: polls alternate RXCR/TX-status, both streams complete, and neither starves.
- PIA_POLL_CRLF_EN defined, tx_data=0x0D: writes 0x0D then 0x0A with one tx_ready pulse. Assert rst mid-SETTLE: no 0x0A write follows, outputs return to reset values, and INIT_WR repeats.
